fp32_accumulator: RTL

//  Streaming FP32 adder/accumulator downstream of the FP32 multiplier; together they form a dot-product/MAC path.

---
 rtl/fp32_pkg.sv | 37 +++
 rtl/fp32_lzc.sv | 27 ++
 rtl/fp32_accumulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 number-model definitions for the multiplier/accumulator MAC path.
// exp==0 means zero; there are no denormals and no NaN, and results truncate.
package fp32_pkg;

  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_FRAC_W   = 23;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [30:0] FP32_INF_MAG  = 31'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } acc_state_t;

  function automatic logic fp32_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [FP32_EXP_W-1:0] fp32_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [FP32_FRAC_W-1:0] fp32_frac(input logic [31:0] v);
    return v[22:0];
  endfunction

  // Mantissa with the hidden one restored; a zero exponent means a zero value.
  function automatic logic [FP32_FRAC_W:0] fp32_mant(input logic [31:0] v);
    return (fp32_exp(v) == 8'd0) ? 24'd0 : {1'b1, fp32_frac(v)};
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Combinational leading-zero counter used to normalise the accumulator sum.
// An all-zero input reports W.
module fp32_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] lzc
);

  logic found_s;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lzc     = CW'(W);
    found_s = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found_s && din[i]) begin
        lzc     = CW'(W - 1 - i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp32_accumulator.sv
// Streaming FP32 packet accumulator: one element in flight through ALIGN/ADD/NORM,
// emitting the truncated FP32 sum and element count when the last element retires.
module fp32_accumulator
  import fp32_pkg::*;
#(
  parameter int GUARD_BITS = 3,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count
);

  localparam int MANT_W = 24 + GUARD_BITS;
  localparam int LZC_W  = $clog2(MANT_W + 1);

  acc_state_t              state_r;
  logic [31:0]             acc_r;
  logic [31:0]             addend_r;
  logic                    last_r;
  logic [COUNT_W-1:0]      count_r;
  logic [MANT_W-1:0]       mant_a_r;
  logic [MANT_W-1:0]       mant_b_r;
  logic                    sign_a_r;
  logic                    sign_b_r;
  logic [FP32_EXP_W-1:0]   exp_r;
  logic [MANT_W:0]         sum_r;
  logic                    sum_sign_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [31:0]             out_data_r;
  logic [COUNT_W-1:0]      out_count_r;

  logic [FP32_EXP_W-1:0]   exp_acc_s;
  logic [FP32_EXP_W-1:0]   exp_add_s;
  logic [FP32_EXP_W-1:0]   exp_diff_s;
  logic [FP32_EXP_W-1:0]   exp_max_s;
  logic [MANT_W-1:0]       mant_acc_s;
  logic [MANT_W-1:0]       mant_add_s;
  logic [MANT_W-1:0]       align_a_s;
  logic [MANT_W-1:0]       align_b_s;
  logic [MANT_W:0]         sum_s;
  logic                    sum_sign_s;
  logic [LZC_W-1:0]        lzc_s;
  logic [MANT_W-1:0]       norm_mant_s;
  logic [9:0]              norm_exp_s;
  logic [FP32_FRAC_W-1:0]  norm_frac_s;
  logic [31:0]             acc_next_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;

  // Align: shift the smaller-exponent mantissa right; shifts past the width give zero.
  always_comb begin
    exp_acc_s  = fp32_exp(acc_r);
    exp_add_s  = fp32_exp(addend_r);
    mant_acc_s = {fp32_mant(acc_r), {GUARD_BITS{1'b0}}};
    mant_add_s = {fp32_mant(addend_r), {GUARD_BITS{1'b0}}};
    if (exp_acc_s >= exp_add_s) begin
      exp_diff_s = exp_acc_s - exp_add_s;
      exp_max_s  = exp_acc_s;
      align_a_s  = mant_acc_s;
      align_b_s  = (exp_diff_s >= 8'(MANT_W)) ? {MANT_W{1'b0}} : (mant_add_s >> exp_diff_s);
    end else begin
      exp_diff_s = exp_add_s - exp_acc_s;
      exp_max_s  = exp_add_s;
      align_a_s  = (exp_diff_s >= 8'(MANT_W)) ? {MANT_W{1'b0}} : (mant_acc_s >> exp_diff_s);
      align_b_s  = mant_add_s;
    end
  end

  // Add: sign-magnitude add/subtract; an exact cancellation yields +0.
  always_comb begin
    if (sign_a_r == sign_b_r) begin
      sum_s      = {1'b0, mant_a_r} + {1'b0, mant_b_r};
      sum_sign_s = sign_a_r;
    end else if (mant_a_r >= mant_b_r) begin
      sum_s      = {1'b0, mant_a_r - mant_b_r};
      sum_sign_s = (mant_a_r == mant_b_r) ? 1'b0 : sign_a_r;
    end else begin
      sum_s      = {1'b0, mant_b_r - mant_a_r};
      sum_sign_s = sign_b_r;
    end
  end

  fp32_lzc #(.W(MANT_W)) u_lzc (
    .din (sum_r[MANT_W-1:0]),
    .lzc (lzc_s)
  );

  // Normalise, saturate to infinity, flush underflow, and truncate guard bits.
  always_comb begin
    if (sum_r[MANT_W]) begin
      norm_mant_s = sum_r[MANT_W:1];
      norm_exp_s  = {2'b00, exp_r} + 10'd1;
    end else begin
      norm_mant_s = sum_r[MANT_W-1:0] << lzc_s;
      norm_exp_s  = {2'b00, exp_r} - 10'(lzc_s);
    end
    norm_frac_s = FP32_FRAC_W'(norm_mant_s >> GUARD_BITS);
    if (sum_r == {(MANT_W + 1){1'b0}}) begin
      acc_next_s = FP32_POS_ZERO;
    end else if (!norm_exp_s[9] && (norm_exp_s >= 10'd255)) begin
      acc_next_s = {sum_sign_r, FP32_INF_MAG};
    end else if (norm_exp_s[9] || (norm_exp_s == 10'd0)) begin
      acc_next_s = FP32_POS_ZERO;
    end else begin
      acc_next_s = {sum_sign_r, norm_exp_s[7:0], norm_frac_s};
    end
  end

  // Control FSM and all datapath/pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= FP32_POS_ZERO;
      addend_r    <= 32'h0000_0000;
      last_r      <= 1'b0;
      count_r     <= {COUNT_W{1'b0}};
      mant_a_r    <= {MANT_W{1'b0}};
      mant_b_r    <= {MANT_W{1'b0}};
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      exp_r       <= 8'd0;
      sum_r       <= {(MANT_W + 1){1'b0}};
      sum_sign_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_count_r <= {COUNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            addend_r   <= in_data;
            last_r     <= in_last;
            count_r    <= count_r + COUNT_W'(1);
            in_ready_r <= 1'b0;
            state_r    <= ALIGN;
          end
        end
        ALIGN: begin
          mant_a_r <= align_a_s;
          mant_b_r <= align_b_s;
          sign_a_r <= fp32_sign(acc_r);
          sign_b_r <= fp32_sign(addend_r);
          exp_r    <= exp_max_s;
          state_r  <= ADD;
        end
        ADD: begin
          sum_r      <= sum_s;
          sum_sign_r <= sum_sign_s;
          state_r    <= NORM;
        end
        NORM: begin
          acc_r <= acc_next_s;
          if (last_r) begin
            out_data_r  <= acc_next_s;
            out_count_r <= count_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            acc_r       <= FP32_POS_ZERO;
            count_r     <= {COUNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
